// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame controller.
// State encoding, default data width and parity-type constants.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/parity_calc.sv
// Parity bit for one data word.
// Even parity is the XOR-reduce of the data; odd parity is its inverse.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  PAR_TYP,
  output logic                  par_bit
);

  assign par_bit = (PAR_TYP == PAR_ODD) ? ~(^data) : ^data;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start, data via serializer,
// optional parity, stop. Inputs are latched only in IDLE.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA_IN,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t state;
  state_t nxt;

  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_bit;
  logic                  accept;

  assign accept = (state == IDLE) && DATA_VALID;

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (P_DATA_IN),
    .PAR_TYP(PAR_TYP),
    .par_bit(par_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Frame attributes are frozen at acceptance for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      p_data_q  <= P_DATA_IN;
      par_en_q  <= PAR_EN;
      par_bit_q <= par_bit;
    end
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == IDLE):   nxt = DATA_VALID ? START : IDLE;
      (state == START):  nxt = DATA;
      (state == DATA): begin
        if (ser_done) nxt = par_en_q ? PARITY : STOP;
      end
      (state == PARITY): nxt = STOP;
      (state == STOP):   nxt = IDLE;
      default:           nxt = IDLE;
    endcase
  end

  always_comb begin
    ser_en = 1'b0;
    TX_OUT = 1'b1;
    Busy   = 1'b1;
    unique case (1'b1)
      (state == IDLE):   Busy = 1'b0;
      (state == START): begin
        ser_en = 1'b1;
        TX_OUT = 1'b0;
      end
      (state == DATA): begin
        ser_en = ~ser_done;
        TX_OUT = ser_data;
      end
      (state == PARITY): TX_OUT = par_bit_q;
      (state == STOP):   TX_OUT = 1'b1;
      default: begin
        Busy   = 1'b0;
        TX_OUT = 1'b1;
      end
    endcase
  end

  assign P_DATA = p_data_q;

endmodule

// File: doc/uart_tx_frame_ctrl.md
UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame data width in bits.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port P_DATA_IN  input  DATA_WIDTH  parallel byte offered by the upstream source.
REQ-005 SHALL have port DATA_VALID  input  1  P_DATA_IN valid; sampled only in IDLE.
REQ-006 SHALL have port PAR_EN  input  1  1 = append parity bit; sampled with the data.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity; sampled with the data.
REQ-008 SHALL have port ser_data  input  1  bit stream returned by the serializer.
REQ-009 SHALL have port ser_done  input  1  serializer flag, high with the last data bit.
REQ-010 SHALL have port P_DATA  output  DATA_WIDTH  latched frame data driven to the serializer.
REQ-011 SHALL have port ser_en  output  1  serializer enable.
REQ-012 SHALL have port TX_OUT  output  1  UART line; idle high.
REQ-013 SHALL have port Busy  output  1  frame in progress; DATA_VALID ignored while high.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: DATA_VALID=1 at an edge SHALL latch P_DATA_IN, PAR_EN, PAR_TYP and the computed parity bit; next state START.
REQ-016 START SHALL last exactly one cycle; next state DATA.
REQ-017 DATA SHALL persist until ser_done=1; on that edge next state PARITY if latched PAR_EN=1, else STOP.
REQ-018 PARITY and STOP SHALL each last exactly one cycle; PARITY -> STOP -> IDLE.
REQ-019 ser_en SHALL be (state==START) or (state==DATA and ser_done==0), decoded from registered state, so serializer bit 0 appears on the first DATA cycle and ser_en drops after the last bit.
REQ-020 TX_OUT SHALL be a mux of registered sources: IDLE 1, START 0, DATA ser_data, PARITY latched parity, STOP 1.
REQ-021 Parity SHALL be XOR-reduce of the data for even and its inverse for odd, computed on P_DATA_IN at acceptance.
REQ-022 Busy SHALL be 1 in every state except IDLE.
REQ-023 Frame length SHALL be 1+DATA_WIDTH+1 cycles without parity and 2+DATA_WIDTH+1 with parity; minimum one IDLE cycle between frames.
REQ-024 Changes on P_DATA_IN, PAR_EN, PAR_TYP or DATA_VALID while Busy=1 SHALL have no effect on the frame in flight.
REQ-025 DATA_VALID held high continuously SHALL start a new frame at the end of each IDLE cycle.
REQ-026 ser_done outside DATA SHALL be ignored.

Reset
REQ-027 RST low SHALL immediately force state IDLE, P_DATA 0, latched parity and PAR_EN 0, ser_en 0, TX_OUT 1, Busy 0, including mid-frame.
REQ-028 After RST release the first DATA_VALID edge SHALL be accepted normally.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state encoding, default DATA_WIDTH and PAR_TYP constants (EVEN=0, ODD=1).
REQ-030 Parity SHALL be a sub-module parity_calc (inputs data, PAR_TYP; output par_bit); the remainder is a single FSM module.
REQ-031 Verification SHALL use this block connected to the team's existing serializer.

Verification
REQ-032 0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles after acceptance; Busy high exactly 11 cycles.
REQ-033 0xA5, PAR_EN=1, PAR_TYP=1 -> parity cycle TX_OUT=1; all other bits as REQ-032.
REQ-034 0x3C, PAR_EN=0 -> TX_OUT 0,0,0,1,1,1,1,0,0,1 (10 cycles); ser_en high exactly 8 cycles.
REQ-035 Accept 0x0F, then present DATA_VALID=1 with 0xFF during DATA -> transmitted bits remain 0x0F; 0xFF not sent.
REQ-036 RST low during the 4th DATA cycle -> TX_OUT=1, Busy=0, ser_en=0 before the next edge; next frame 0x55 correct.
REQ-037 DATA_VALID held high with 0x81, PAR_EN=0 -> back-to-back frames separated by exactly one IDLE cycle with TX_OUT=1.
